udp_tx_arbiter: RTL
===================

UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the UDP transmit path.
REQ-002 Parameter MAX_LEN, default 1472: largest legal payload in bytes.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N_REQ  requester i has a packet pending (level).
REQ-006 req_len  input  16*N_REQ  payload byte count of requester i at [16i+15:16i].
REQ-007 req_sport  input  16*N_REQ  UDP source port of requester i.
REQ-008 req_dport  input  16*N_REQ  UDP destination port of requester i.
REQ-009 req_data  input  32*N_REQ  current payload word of requester i (first-word-fall-through); first byte at [31:24].
REQ-010 gnt  output  N_REQ  one-hot grant, held for the whole packet.
REQ-011 rd  output  N_REQ  pop strobe: requester i advances req_data to the next word.
REQ-012 tx_rdy  input  1  downstream accepts the presented word this cycle.
REQ-013 tx_op_st, tx_op, tx_op_end  output  1 each  word valid, first-word and last-word flags.
REQ-014 tx_data  output  32  UDP header or payload word.
REQ-015 drop_err  output  1  one-cycle pulse when a granted request is rejected.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, HDR0, HDR1, DATA, DROP, GAP.
REQ-018 IDLE with |req=1: select winner, set gnt, latch len/sport/dport of winner; go to DROP if len==0 or len>MAX_LEN, else HDR0.
REQ-019 Arbitration round-robin: search starts at rr_ptr, ascending, wrapping at N_REQ-1; rr_ptr <= winner+1 (mod N_REQ) on every acceptance, including drops.
REQ-020 HDR0: tx_op=1, tx_op_st=1, tx_data={sport,dport}; on tx_rdy go HDR1.
REQ-021 HDR1: tx_op=1, tx_data={len+8, 16'h0000} (checksum field zero); on tx_rdy go DATA; 16-bit add, no overflow since len<=MAX_LEN.
REQ-022 DATA: word count = ceil(len/4); tx_op=1, tx_data=req_data of winner; rd[winner]=tx_rdy (combinational), other rd bits 0.
REQ-023 Last DATA word: tx_op_end=1; bytes beyond len zeroed (len mod 4 = 1,2,3 keeps top 1,2,3 bytes); on tx_rdy go GAP.
REQ-024 Backpressure: while tx_op=1 and tx_rdy=0, state, tx_data and all flags held unchanged; rd=0.
REQ-025 DROP: one cycle, gnt held, drop_err=1, tx_op=0, no rd; go GAP.
REQ-026 GAP: one cycle, gnt=0, tx_op=0; go IDLE; req still high in IDLE is treated as a new packet.
REQ-027 Requester fields (len, ports) must be stable only in the IDLE acceptance cycle; latched copies are used thereafter.
REQ-028 tx_op_st and tx_op_end never both high (minimum packet = 3 words).
REQ-029 Latency: req sampled in IDLE at edge N -> HDR0 word presented in cycle N+1; a 3-word packet with tx_rdy=1 throughout is followed by GAP and IDLE, next HDR0 at N+6.
REQ-030 req deasserted mid-packet is ignored; the packet completes.

Reset
REQ-031 rst_n low: state IDLE, rr_ptr=0, gnt=0, rd=0, tx_op/tx_op_st/tx_op_end=0, tx_data=0, drop_err=0, busy=0, latches=0.
REQ-032 Reset mid-packet aborts immediately; no tx_op_end is emitted; first post-reset grant follows REQ-019 from rr_ptr=0.

Verification
REQ-033 req=4'b0001, len=5, sport=0x1234, dport=0x0035, data 0xAABBCCDD,0xEEFF0011, tx_rdy=1 -> words 0x12340035, 0x000D0000, 0xAABBCCDD, 0xEE000000; st on word 0, end on word 3; rd[0] high 2 cycles.
REQ-034 req=4'b1111 continuously, all len=4 -> gnt order 0,1,2,3,0; each packet 3 words; GAP cycle between packets.
REQ-035 req=4'b0010, len=0 then len=1473 -> gnt=4'b0010 one cycle each, drop_err pulse each, tx_op stays 0, rr_ptr=2.
REQ-036 len=8, tx_rdy low for 3 cycles during HDR1 and first DATA word -> tx_data/flags stable, rd=0 while stalled, output sequence unchanged.
REQ-037 rst_n low during DATA of requester 2 -> all outputs 0 same cycle; after release with req=4'b0110, first grant to requester 1.

Source files
------------

// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - round-robin arbiter framing UDP header + payload onto one tx stream
module udp_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MAX_LEN = 1472
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [16*N_REQ-1:0]   req_len_i,
    input  logic [16*N_REQ-1:0]   req_sport_i,
    input  logic [16*N_REQ-1:0]   req_dport_i,
    input  logic [32*N_REQ-1:0]   req_data_i,
    output logic [N_REQ-1:0]      gnt_o,
    output logic [N_REQ-1:0]      rd_o,
    input  logic                  tx_rdy_i,
    output logic                  tx_op_st_o,
    output logic                  tx_op_o,
    output logic                  tx_op_end_o,
    output logic [31:0]           tx_data_o,
    output logic                  drop_err_o,
    output logic                  busy_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA, S_DROP, S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]  win_q, win_d;
    logic [15:0]    len_q, len_d;
    logic [15:0]    sport_q, sport_d;
    logic [15:0]    dport_q, dport_d;
    logic [14:0]    wcnt_q, wcnt_d;

    logic           found;
    logic [IW-1:0]  pick;
    int             idx;
    logic [15:0]    pick_len;
    logic [16:0]    len_p3;
    logic           last_word;
    logic [31:0]    data_word;

    // Round-robin search starting at rr_ptr, ascending with wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    assign pick_len  = req_len_i[16*pick +: 16];
    assign len_p3    = {1'b0, len_q} + 17'd3;
    assign last_word = (wcnt_q == (len_p3[16:2] - 15'd1));
    assign data_word = req_data_i[32*win_q +: 32];

    // State and latched packet context; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            len_q    <= '0;
            sport_q  <= '0;
            dport_q  <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            len_q    <= len_d;
            sport_q  <= sport_d;
            dport_q  <= dport_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Next state: accept in IDLE, advance header/data words on tx_rdy.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        len_d    = len_q;
        sport_d  = sport_q;
        dport_d  = dport_q;
        wcnt_d   = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d    = pick;
                    rr_ptr_d = (int'(pick) == N_REQ - 1) ? '0 : pick + 1'b1;
                    len_d    = pick_len;
                    sport_d  = req_sport_i[16*pick +: 16];
                    dport_d  = req_dport_i[16*pick +: 16];
                    wcnt_d   = '0;
                    if (pick_len == 16'd0 || int'(pick_len) > MAX_LEN) begin
                        state_d = S_DROP;
                    end else begin
                        state_d = S_HDR0;
                    end
                end
            end
            S_HDR0: if (tx_rdy_i) state_d = S_HDR1;
            S_HDR1: if (tx_rdy_i) state_d = S_DATA;
            S_DATA: begin
                if (tx_rdy_i) begin
                    if (last_word) state_d = S_GAP;
                    else           wcnt_d  = wcnt_q + 15'd1;
                end
            end
            S_DROP: state_d = S_GAP;
            S_GAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; the final data word is masked past len.
    always_comb begin
        gnt_o       = '0;
        rd_o        = '0;
        tx_op_o     = 1'b0;
        tx_op_st_o  = 1'b0;
        tx_op_end_o = 1'b0;
        tx_data_o   = '0;
        drop_err_o  = 1'b0;
        busy_o      = (state_q != S_IDLE);
        case (state_q)
            S_HDR0: begin
                gnt_o[win_q] = 1'b1;
                tx_op_o      = 1'b1;
                tx_op_st_o   = 1'b1;
                tx_data_o    = {sport_q, dport_q};
            end
            S_HDR1: begin
                gnt_o[win_q] = 1'b1;
                tx_op_o      = 1'b1;
                tx_data_o    = {len_q + 16'd8, 16'h0000};
            end
            S_DATA: begin
                gnt_o[win_q] = 1'b1;
                rd_o[win_q]  = tx_rdy_i;
                tx_op_o      = 1'b1;
                tx_data_o    = data_word;
                if (last_word) begin
                    tx_op_end_o = 1'b1;
                    case (len_q[1:0])
                        2'd1:    tx_data_o = {data_word[31:24], 24'h0};
                        2'd2:    tx_data_o = {data_word[31:16], 16'h0};
                        2'd3:    tx_data_o = {data_word[31:8], 8'h0};
                        default: tx_data_o = data_word;
                    endcase
                end
            end
            S_DROP: begin
                gnt_o[win_q] = 1'b1;
                drop_err_o   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
